// File: rtl/seg_mon_pkg.sv
// Shared constants, frame record type and segment decoder for the 7-segment frame monitor.
// Segment bit order is [0]=a .. [6]=g, [7]=dp, active-high.
package seg_mon_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [4:0] CODE_BLANK = 5'h10;
  localparam logic [4:0] CODE_UNK   = 5'h1F;

  // Decimal point is masked off before matching; it never changes the code.
  function automatic logic [4:0] seg_decode(input logic [7:0] seg);
    logic [4:0] code;
    case (seg & 8'h7F)
      {1'b0, SEG_0}:     code = 5'h00;
      {1'b0, SEG_1}:     code = 5'h01;
      {1'b0, SEG_2}:     code = 5'h02;
      {1'b0, SEG_3}:     code = 5'h03;
      {1'b0, SEG_4}:     code = 5'h04;
      {1'b0, SEG_5}:     code = 5'h05;
      {1'b0, SEG_6}:     code = 5'h06;
      {1'b0, SEG_7}:     code = 5'h07;
      {1'b0, SEG_8}:     code = 5'h08;
      {1'b0, SEG_9}:     code = 5'h09;
      {1'b0, SEG_A}:     code = 5'h0A;
      {1'b0, SEG_B}:     code = 5'h0B;
      {1'b0, SEG_C}:     code = 5'h0C;
      {1'b0, SEG_D}:     code = 5'h0D;
      {1'b0, SEG_E}:     code = 5'h0E;
      {1'b0, SEG_F}:     code = 5'h0F;
      {1'b0, SEG_BLANK}: code = CODE_BLANK;
      default:           code = CODE_UNK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg_stab_filter.sv
// Input register plus stability filter: flags when the registered segment pattern
// has matched the current candidate for STABLE_CYC consecutive checks.
module seg_stab_filter #(
  parameter int STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in,
  output logic       stable,
  output logic [7:0] pattern
);

  localparam int SW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC - 1);

  logic [7:0]    seg_q;
  logic [7:0]    cand;
  logic [SW-1:0] stab_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q    <= 8'h00;
      cand     <= 8'h00;
      stab_cnt <= '0;
    end else begin
      seg_q <= seg_in;
      if (seg_q != cand) begin
        cand     <= seg_q;
        stab_cnt <= '0;
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + SW'(1);
      end
    end
  end

  // Stays high for as long as the pattern holds; the top only acts when it differs from acc.
  assign stable  = (seg_q == cand) && (stab_cnt == STAB_MAX);
  assign pattern = cand;

endmodule

// File: rtl/seg_frame_monitor.sv
// Watches the 7-segment bus, accepts stable new patterns, decodes them and offers each
// frame on a valid/ready port. Optional period measurement: define SEG_PERIOD_MEAS_EN.
module seg_frame_monitor
  import seg_mon_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int PERIOD_W   = 16,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          seg_in,
  input  logic                out_ready,
  input  logic                ovf_clr,
  output logic                out_valid,
  output logic [4:0]          out_code,
  output logic                out_dp,
  output logic [7:0]          out_raw,
  output logic [PERIOD_W-1:0] out_period,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic                overflow
);

  logic       stable;
  logic [7:0] pattern;
  logic [7:0] acc;
  logic       accept;
  logic       load;
  logic       drop;

  seg_stab_filter #(.STABLE_CYC(STABLE_CYC)) u_filter (
    .clk     (clk),
    .rst     (rst),
    .seg_in  (seg_in),
    .stable  (stable),
    .pattern (pattern)
  );

  // Handshake: a record transfers on any edge where out_valid && out_ready; while
  // out_valid is high and out_ready low, out_* are frozen and new frames are dropped.
  assign accept = stable && (pattern != acc);
  assign load   = accept && (!out_valid || out_ready);
  assign drop   = accept && out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= 8'h00;
      out_valid <= 1'b0;
      out_code  <= CODE_BLANK;
      out_dp    <= 1'b0;
      out_raw   <= 8'h00;
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        acc       <= pattern;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (load) begin
        out_valid <= 1'b1;
        out_code  <= seg_decode(pattern);
        out_dp    <= pattern[7];
        out_raw   <= pattern;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef SEG_PERIOD_MEAS_EN
  logic [PERIOD_W-1:0] per_cnt;
  logic [PERIOD_W-1:0] per_sat;

  // Saturating: a very slow display reads as "at least all-ones cycles".
  assign per_sat = (&per_cnt) ? per_cnt : per_cnt + PERIOD_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt    <= '0;
      out_period <= '0;
    end else begin
      if (accept) begin
        per_cnt <= '0;
      end else begin
        per_cnt <= per_sat;
      end
      if (load) begin
        out_period <= per_sat;
      end
    end
  end
`else
  assign out_period = '0;
`endif

endmodule

// File: tb/tb_seg_frame_monitor.sv
// Randomized bench for seg_frame_monitor against a run-length reference model, with
// directed scenarios pinning reset, latency, glitch rejection, handshake, overflow and decode.
module tb_seg_frame_monitor;

  localparam int SC = 4;
  localparam int PW = 6;
  localparam int CW = 4;
  localparam int RW = 5 + 1 + 8 + PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    seg_in = 8'h00;
  logic          out_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          out_valid;
  logic [4:0]    out_code;
  logic          out_dp;
  logic [7:0]    out_raw;
  logic [PW-1:0] out_period;
  logic [CW-1:0] frame_cnt;
  logic          overflow;

  seg_frame_monitor #(.STABLE_CYC(SC), .PERIOD_W(PW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .out_ready  (out_ready),
    .ovf_clr    (ovf_clr),
    .out_valid  (out_valid),
    .out_code   (out_code),
    .out_dp     (out_dp),
    .out_raw    (out_raw),
    .out_period (out_period),
    .frame_cnt  (frame_cnt),
    .overflow   (overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [4:0] ref_code(input logic [7:0] p);
    logic [4:0] c;
    c = 5'h1F;
    if (p[6:0] == 7'h00) c = 5'h10;
    for (int i = 0; i < 16; i++)
      if (p[6:0] == hex_tab[i]) c = 5'(i);
    return c;
  endfunction

  function automatic logic [PW-1:0] ref_period(input int d);
`ifdef SEG_PERIOD_MEAS_EN
    if (d >= (1 << PW) - 1) return '1;
    return PW'(d);
`else
    return (d < 0) ? '1 : '0;
`endif
  endfunction

  bit            live = 1'b0;
  int            cyc = 0;
  int            last_acc = 0;
  int            run_len = 1;
  logic [7:0]    last_s = 8'h00;
  logic [7:0]    m_acc = 8'h00;
  logic          m_valid = 1'b0;
  logic [4:0]    m_code = 5'h10;
  logic          m_dp = 1'b0;
  logic [7:0]    m_raw = 8'h00;
  logic [PW-1:0] m_per = '0;
  logic [CW-1:0] m_fc = '0;
  logic          m_ovf = 1'b0;
  logic [RW-1:0] exp_q[$];

  // A pattern is accepted once the last SC+1 register samples all equal it and it
  // differs from the last accepted pattern.
  always @(posedge clk) begin : model
    bit hit;
    bit drop;
    cyc++;
    if (rst) begin
      live = 1'b1;
      m_valid = 1'b0; m_code = 5'h10; m_dp = 1'b0; m_raw = 8'h00; m_per = '0;
      m_fc = '0; m_ovf = 1'b0; m_acc = 8'h00;
      last_acc = cyc; last_s = 8'h00; run_len = 1;
      exp_q.delete();
    end else begin
      hit  = (run_len >= SC + 1) && (last_s != m_acc);
      drop = hit && m_valid && !out_ready;
      if (hit) begin
        m_acc = last_s;
        m_fc  = m_fc + 1'b1;
        if (drop) begin
          m_ovf = 1'b1;
        end else begin
          m_valid = 1'b1;
          m_code  = ref_code(last_s);
          m_dp    = last_s[7];
          m_raw   = last_s;
          m_per   = ref_period(cyc - last_acc);
          exp_q.push_back({m_code, m_dp, m_raw, m_per});
        end
        last_acc = cyc;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (!drop && ovf_clr) m_ovf = 1'b0;
      if (seg_in == last_s) run_len++;
      else begin
        last_s = seg_in;
        run_len = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always begin
    @(posedge clk);
    #1;
    if (live) begin
      check("out_valid",  32'(out_valid),  32'(m_valid));
      check("out_code",   32'(out_code),   32'(m_code));
      check("out_dp",     32'(out_dp),     32'(m_dp));
      check("out_raw",    32'(out_raw),    32'(m_raw));
      check("out_period", 32'(out_period), 32'(m_per));
      check("frame_cnt",  32'(frame_cnt),  32'(m_fc));
      check("overflow",   32'(overflow),   32'(m_ovf));
    end
  end

  // ---------------- scoreboard on transfers ----------------
  always @(negedge clk) begin
    if (live && !rst && out_valid && out_ready) begin
      check("sb_depth", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check("sb_record", 32'({out_code, out_dp, out_raw, out_period}), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic rand_segment();
    int sel;
    int hold;
    sel = $urandom_range(0, 19);
    if (sel < 16) seg_in = {1'b0, hex_tab[sel]};
    else if (sel < 18) seg_in = 8'h00;
    else seg_in = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 3) == 0) seg_in[7] = 1'b1;
    hold = $urandom_range(1, 9);
    for (int k = 0; k < hold; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      cyc_n(1);
    end
    rst = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    cyc_n(2);
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_code", 32'(out_code), 32'h10);

    // 1: first frame latency and decode
    seg_in = 8'h06;
    cyc_n(5);
    check("t1_early", 32'(out_valid), 32'd0);
    cyc_n(1);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_code", 32'(out_code), 32'h01);
    check("t1_raw", 32'(out_raw), 32'h06);
    check("t1_dp", 32'(out_dp), 32'd0);
    check("t1_cnt", 32'(frame_cnt), 32'd1);
`ifdef SEG_PERIOD_MEAS_EN
    check("t1_period", 32'(out_period), 32'd6);
`endif

    // 2: short glitch and return to acc
    seg_in = 8'h5B;
    cyc_n(3);
    seg_in = 8'h06;
    cyc_n(8);
    check("t2_raw", 32'(out_raw), 32'h06);
    check("t2_cnt", 32'(frame_cnt), 32'd1);
    check("t2_ovf", 32'(overflow), 32'd0);

    // 3: dp change is a new frame; period between accepts
    out_ready = 1'b1;
    seg_in = 8'h3F;
    cyc_n(6);
    check("t3a_code", 32'(out_code), 32'h00);
    check("t3a_dp", 32'(out_dp), 32'd0);
    cyc_n(14);
    seg_in = 8'hBF;
    cyc_n(6);
    check("t3b_valid", 32'(out_valid), 32'd1);
    check("t3b_code", 32'(out_code), 32'h00);
    check("t3b_dp", 32'(out_dp), 32'd1);
`ifdef SEG_PERIOD_MEAS_EN
    check("t3b_period", 32'(out_period), 32'd20);
`else
    check("t3b_period", 32'(out_period), 32'd0);
`endif

    // 4: backpressure drop and overflow clear
    cyc_n(1);
    out_ready = 1'b0;
    seg_in = 8'h06;
    cyc_n(6);
    check("t4a_code", 32'(out_code), 32'h01);
    seg_in = 8'h5B;
    cyc_n(6);
    check("t4b_code", 32'(out_code), 32'h01);
    check("t4b_ovf", 32'(overflow), 32'd1);
    check("t4b_cnt", 32'(frame_cnt), 32'd5);
    ovf_clr = 1'b1;
    cyc_n(1);
    ovf_clr = 1'b0;
    check("t4c_ovf", 32'(overflow), 32'd0);

    // 5: unknown and blank decode
    out_ready = 1'b1;
    seg_in = 8'h49;
    cyc_n(6);
    check("t5a_code", 32'(out_code), 32'h1F);
    seg_in = 8'h00;
    cyc_n(6);
    check("t5b_code", 32'(out_code), 32'h10);
    check("t5b_cnt", 32'(frame_cnt), 32'd7);

    // 6: reset while holding a record
    out_ready = 1'b0;
    cyc_n(1);
    check("t6_held", 32'(out_valid), 32'd1);
    rst = 1'b1;
    cyc_n(1);
    rst = 1'b0;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_code", 32'(out_code), 32'h10);
    check("t6_raw", 32'(out_raw), 32'h00);
    check("t6_period", 32'(out_period), 32'd0);
    check("t6_cnt", 32'(frame_cnt), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);

    // 7: long idle saturates the period counter
    cyc_n(80);
    seg_in = 8'h06;
    cyc_n(6);
    check("t7_raw", 32'(out_raw), 32'h06);
`ifdef SEG_PERIOD_MEAS_EN
    check("t7_period", 32'(out_period), 32'd63);
`else
    check("t7_period", 32'(out_period), 32'd0);
`endif

    // random phase
    for (int s = 0; s < 500; s++) rand_segment();
    cyc_n(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
